// File: rtl/noc_port_arbiter_pkg.sv
// rtl/noc_port_arbiter_pkg.sv - shared NoC widths, arbiter state encoding and round-robin helper
package noc_port_arbiter_pkg;

    localparam int NOC_DATA_WIDTH = 32;
    localparam int NOC_NUM_REQ    = 4;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Index following idx, wrapping at n-1 back to 0.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// rtl/noc_rr_arbiter.sv - combinational round-robin one-hot grant starting at a pointer
module noc_rr_arbiter
    import noc_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NOC_NUM_REQ,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,        // eligible requesters
    input  logic [IDX_W-1:0]   ptr,        // highest-priority index this cycle
    output logic [NUM_REQ-1:0] grant,      // one-hot winner
    output logic [IDX_W-1:0]   grant_idx,  // encoded winner
    output logic               grant_any   // some requester won
);

    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_v;
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        idx       = 0;
        idx_v     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_v = IDX_W'(idx);
            if (!grant_any && req[idx_v]) begin
                grant_any    = 1'b1;
                grant[idx_v] = 1'b1;
                grant_idx    = idx_v;
            end
        end
    end

endmodule

// File: rtl/noc_port_arbiter.sv
// rtl/noc_port_arbiter.sv - packet-locking round-robin arbiter of NUM_REQ flit streams onto one link
module noc_port_arbiter
    import noc_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NOC_NUM_REQ,
    parameter int DATA_W  = NOC_DATA_WIDTH,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      noc_clk,
    input  logic                      rst,              // synchronous, active-high
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_flit,         // requester i at [i*DATA_W +: DATA_W]
    input  logic [NUM_REQ-1:0]        req_is_header,
    input  logic [NUM_REQ-1:0]        req_is_tail,
    output logic                      sender_valid,
    input  logic                      sender_ready,
    output logic [DATA_W-1:0]         sender_flit,
    input  logic                      sender_vc_ready,  // downstream VC can start a packet
    output logic                      sender_is_header,
    output logic                      sender_is_tail,
    output logic [IDX_W-1:0]          owner,            // current or last granted requester
    output logic                      busy,             // packet locked
    output logic                      protocol_err      // sticky until rst
);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   owner_d, acc_idx;
    logic               cool_q, cool_d;
    logic               accept, err_set, slot_free;
    logic [NUM_REQ-1:0] hdr_req, grant;
    logic [IDX_W-1:0]   grant_idx;
    logic               grant_any;

    assign slot_free = !sender_valid || sender_ready;
    assign hdr_req   = req_valid & req_is_header;
    assign busy      = (state_q == ST_LOCKED);

    noc_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .req       (hdr_req),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        owner_d   = owner;
        acc_idx   = owner;
        cool_d    = 1'b0;
        accept    = 1'b0;
        err_set   = 1'b0;
        req_ready = '0;
        if (!rst) begin
            case (state_q)
                ST_IDLE: begin
                    err_set = |(req_valid & ~req_is_header);
                    // cool_q leaves one dead cycle after a locked packet closes,
                    // so a new multi-flit packet never starts right on a tail.
                    if (!cool_q && sender_vc_ready && slot_free && grant_any) begin
                        req_ready = grant;
                        accept    = 1'b1;
                        acc_idx   = grant_idx;
                        owner_d   = grant_idx;
                        if (req_is_tail[grant_idx]) begin
                            rr_ptr_d = IDX_W'(rr_next(int'(grant_idx), NUM_REQ));
                        end else begin
                            state_d = ST_LOCKED;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (slot_free) begin
                        req_ready[owner] = 1'b1;
                        if (req_valid[owner]) begin
                            accept  = 1'b1;
                            // A stray header inside a packet is still forwarded.
                            err_set = req_is_header[owner];
                            if (req_is_tail[owner]) begin
                                state_d  = ST_IDLE;
                                rr_ptr_d = IDX_W'(rr_next(int'(owner), NUM_REQ));
                                cool_d   = 1'b1;
                            end
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge noc_clk) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            rr_ptr_q         <= '0;
            owner            <= '0;
            cool_q           <= 1'b0;
            sender_valid     <= 1'b0;
            sender_flit      <= '0;
            sender_is_header <= 1'b0;
            sender_is_tail   <= 1'b0;
            protocol_err     <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            owner        <= owner_d;
            cool_q       <= cool_d;
            protocol_err <= protocol_err | err_set;
            if (accept) begin
                sender_valid     <= 1'b1;
                sender_flit      <= req_flit[int'(acc_idx)*DATA_W +: DATA_W];
                sender_is_header <= req_is_header[acc_idx];
                sender_is_tail   <= req_is_tail[acc_idx];
            end else if (sender_ready) begin
                sender_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/noc_port_arbiter.md
NOC_PORT_ARBITER -- requirements
Module: noc_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of requesters sharing one output link.
REQ-002 The block SHALL have parameter DATA_W, default `Noc_Data_Width: flit width in bits.
REQ-003 The block SHALL have port noc_clk, input, 1: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 The block SHALL have port req_valid, input, NUM_REQ: per-requester flit valid.
REQ-006 The block SHALL have port req_ready, output, NUM_REQ: per-requester flit accepted.
REQ-007 The block SHALL have port req_flit, input, NUM_REQ*DATA_W: packed flits; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 The block SHALL have port req_is_header, input, NUM_REQ: per-requester header marker.
REQ-009 The block SHALL have port req_is_tail, input, NUM_REQ: per-requester tail marker.
REQ-010 The block SHALL have port sender_valid, output, 1: output flit valid.
REQ-011 The block SHALL have port sender_ready, input, 1: downstream accepts the flit.
REQ-012 The block SHALL have port sender_flit, output, DATA_W: output flit.
REQ-013 The block SHALL have port sender_vc_ready, input, 1: downstream VC can take a new packet.
REQ-014 The block SHALL have ports sender_is_header and sender_is_tail, output, 1 each: markers travelling with sender_flit.
REQ-015 The block SHALL have port owner, output, clog2(NUM_REQ): index of the current or last granted requester.
REQ-016 The block SHALL have port busy, output, 1: high while a packet is locked.
REQ-017 The block SHALL have port protocol_err, output, 1: sticky error flag.

Function
REQ-018 A transfer SHALL occur on req i when req_valid[i]&&req_ready[i], and on the output when sender_valid&&sender_ready.
REQ-019 The output SHALL be a one-entry register; the slot is free when !sender_valid||sender_ready.
REQ-020 A flit accepted in cycle t SHALL appear on sender_* in cycle t+1; back-to-back flits SHALL sustain 1 flit/cycle.
REQ-021 The FSM SHALL have states IDLE and LOCKED.
REQ-022 In IDLE, eligible requesters SHALL be those with req_valid&&req_is_header; a grant SHALL issue only when sender_vc_ready=1 and the slot is free.
REQ-023 The grant SHALL be round-robin, searching upward from rr_ptr and wrapping at NUM_REQ-1 to 0.
REQ-024 Arbitration and header acceptance SHALL occur in the same cycle: req_ready[g]=1, and all other req_ready bits SHALL be 0.
REQ-025 An accepted header without tail SHALL move the FSM to LOCKED with owner=g and busy=1.
REQ-026 An accepted header+tail (single-flit packet) SHALL keep the FSM in IDLE and set rr_ptr=g+1 mod NUM_REQ.
REQ-027 In LOCKED, req_ready[owner] SHALL equal slot-free, and all other req_ready bits SHALL be 0; sender_vc_ready SHALL be ignored.
REQ-028 In LOCKED, an accepted tail SHALL move the FSM to IDLE with rr_ptr=owner+1 mod NUM_REQ and busy=0.
REQ-029 The FSM SHALL NOT start a new packet in the cycle a tail is accepted; the next header is granted no earlier than the following cycle.
REQ-030 If a requester in IDLE presents req_valid with req_is_header=0, it SHALL NOT be readied and protocol_err SHALL set.
REQ-031 If the owner presents a header while LOCKED, the flit SHALL still be accepted and forwarded, and protocol_err SHALL set.
REQ-032 A held sender flit (sender_valid&&!sender_ready) SHALL keep sender_flit and its markers stable.

Reset
REQ-033 On rst, the block SHALL set state=IDLE, rr_ptr=0, owner=0, busy=0, sender_valid=0, sender_is_header=0, sender_is_tail=0, sender_flit=0, and protocol_err=0.
REQ-034 A reset mid-packet SHALL drop the lock and any buffered flit without emitting a tail; req_ready SHALL be 0 during reset.

Structure
REQ-035 Noc_parameters.v SHALL hold Noc_Data_Width, the default NUM_REQ, and the IDLE/LOCKED encodings.
REQ-036 A combinational sub-module noc_rr_arbiter(NUM_REQ) SHALL compute the one-hot grant from the request vector and rr_ptr.
REQ-037 The implementation SHALL be 120-400 lines of RTL.

Verification
REQ-038 Reqs 0 and 2 each send a 3-flit packet simultaneously, sender_ready=1 -> output is 0H,0B,0T,2H,2B,2T with one idle cycle between packets, and rr_ptr=3.
REQ-039 Req 1 sends 4 flits while sender_ready toggles 1,0,1,0 -> flit order is preserved, values are held while stalled, and req_ready[1] tracks slot-free.
REQ-040 All 4 requesters send single-flit (H+T) packets continuously -> grants rotate 0,1,2,3,0 with no lock.
REQ-041 A header is pending with sender_vc_ready=0 for 5 cycles, then 1 -> no grant for 5 cycles, then the header appears one cycle after sender_vc_ready rises.
REQ-042 Req 3 sends a non-header flit in IDLE -> req_ready[3]=0 and protocol_err=1 on the next cycle, sticky until rst.
REQ-043 rst is asserted after the 2nd flit of a 4-flit packet -> sender_valid=0 and busy=0 the next cycle, and a new header from req 0 is granted first.
